accumulator_serial_rx: RTL and testbench

Receive-side deserializer for the accumulator readout link. It samples the `serialStart`/`serialOut_SA`/`serialOut_CML` stream that `digital_top` produces on `serialClk`, and rebuilds each frame into two parallel accumulator words. It presents those words on a valid/ready output, with framing-error and overrun accounting. It sits in the readout FPGA or test harness, at the far end of the serial link from the chip's accumulator serializer.

---
 rtl/acc_serial_pkg.sv | 18 +
 rtl/accumulator_serial_rx_if.sv | 26 ++
 rtl/serial_lane_shifter.sv | 35 +++
 rtl/accumulator_serial_rx.sv | 141 ++++++++++++++
 tb/tb_accumulator_serial_rx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_serial_pkg.sv
// Shared types and constants for the accumulator serial receiver.
// Holds the FSM state encoding and bit-counter sizing helpers.
package acc_serial_pkg;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rxState_t;

    localparam int ACC_WIDTH_DEFAULT = 16;
    localparam int BIT_IDX_WIDTH = $clog2(ACC_WIDTH_DEFAULT);

    // A one-bit frame still needs a one-bit counter.
    function automatic int idxWidth(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/accumulator_serial_rx_if.sv
// Valid/ready output bundle carrying the two rebuilt lane words.
// master = receiver side, slave = consumer side.
interface accumulator_serial_rx_if #(
    parameter int ACC_WIDTH = acc_serial_pkg::ACC_WIDTH_DEFAULT
) ();

    logic [ACC_WIDTH-1:0] rxWord_SA;
    logic [ACC_WIDTH-1:0] rxWord_CML;
    logic                 rxValid;
    logic                 rxReady;

    modport master (
        output rxWord_SA,
        output rxWord_CML,
        output rxValid,
        input  rxReady
    );

    modport slave (
        input  rxWord_SA,
        input  rxWord_CML,
        input  rxValid,
        output rxReady
    );

endinterface

// File: rtl/serial_lane_shifter.sv
// MSB-first lane deserializer with load (frame start) and shift.
// wordNext shows the word as it will be after this edge.
module serial_lane_shifter #(
    parameter int ACC_WIDTH = acc_serial_pkg::ACC_WIDTH_DEFAULT
) (
    input  logic                 serialClk,
    input  logic                 serialReset,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 bitIn,
    output logic [ACC_WIDTH-1:0] wordNext
);

    logic [ACC_WIDTH-1:0] shiftReg;

    // Start seeds a fresh word; shift appends at the LSB end.
    always_comb begin
        wordNext = shiftReg;
        if (load) begin
            wordNext = ACC_WIDTH'(bitIn);
        end else if (shift) begin
            wordNext = (shiftReg << 1) | ACC_WIDTH'(bitIn);
        end
    end

    // Partial word register, cleared by reset.
    always_ff @(posedge serialClk or posedge serialReset) begin
        if (serialReset) begin
            shiftReg <= '0;
        end else begin
            shiftReg <= wordNext;
        end
    end

endmodule

// File: rtl/accumulator_serial_rx.sv
// Accumulator readout link receiver: frame FSM, bit counter,
// output holding register and framing/overrun statistics.
module accumulator_serial_rx
    import acc_serial_pkg::*;
#(
    parameter int ACC_WIDTH       = ACC_WIDTH_DEFAULT,
    parameter int CNT_WIDTH       = 8,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       serialClk,
    input  logic                       serialReset,
    input  logic                       rxEnable,
    input  logic                       serialStart,
    input  logic                       serialOut_SA,
    input  logic                       serialOut_CML,
    accumulator_serial_rx_if.master    rxIf,
    output logic [FRAME_CNT_WIDTH-1:0] frameCount,
    output logic [CNT_WIDTH-1:0]       framingErrCount,
    output logic [CNT_WIDTH-1:0]       overrunCount,
    output logic                       busy
);

    localparam int IDX_W = idxWidth(ACC_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_WIDTH - 1);

    rxState_t             state;
    rxState_t             stateNext;
    logic [IDX_W-1:0]     bitIdx;
    logic                 load;
    logic                 shift;
    logic                 complete;
    logic                 frameErr;
    logic [ACC_WIDTH-1:0] wordSA;
    logic [ACC_WIDTH-1:0] wordCML;

    serial_lane_shifter #(.ACC_WIDTH(ACC_WIDTH)) u_shiftSA (
        .serialClk   (serialClk),
        .serialReset (serialReset),
        .load        (load),
        .shift       (shift),
        .bitIn       (serialOut_SA),
        .wordNext    (wordSA)
    );

    serial_lane_shifter #(.ACC_WIDTH(ACC_WIDTH)) u_shiftCML (
        .serialClk   (serialClk),
        .serialReset (serialReset),
        .load        (load),
        .shift       (shift),
        .bitIn       (serialOut_CML),
        .wordNext    (wordCML)
    );

    // State register.
    always_ff @(posedge serialClk or posedge serialReset) begin
        if (serialReset) begin
            state <= RX_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and per-edge frame controls.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        shift     = 1'b0;
        complete  = 1'b0;
        frameErr  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (serialStart && rxEnable) begin
                    load = 1'b1;
                    if (ACC_WIDTH == 1) begin
                        complete = 1'b1;
                    end else begin
                        stateNext = RX_SHIFT;
                    end
                end
            end
            RX_SHIFT: begin
                if (serialStart) begin
                    load     = 1'b1;
                    frameErr = 1'b1;
                end else begin
                    shift = 1'b1;
                    if (bitIdx == LAST_IDX) begin
                        complete  = 1'b1;
                        stateNext = RX_IDLE;
                    end
                end
            end
            default: stateNext = RX_IDLE;
        endcase
    end

    // Bit position within the current frame.
    always_ff @(posedge serialClk or posedge serialReset) begin
        if (serialReset) begin
            bitIdx <= '0;
        end else if (load) begin
            bitIdx <= IDX_W'(1);
        end else if (shift) begin
            bitIdx <= bitIdx + 1'b1;
        end
    end

    // Output holding register, frame and overrun accounting.
    always_ff @(posedge serialClk or posedge serialReset) begin
        if (serialReset) begin
            rxIf.rxWord_SA  <= '0;
            rxIf.rxWord_CML <= '0;
            rxIf.rxValid    <= 1'b0;
            frameCount      <= '0;
            overrunCount    <= '0;
        end else if (complete) begin
            if (!rxIf.rxValid || rxIf.rxReady) begin
                rxIf.rxWord_SA  <= wordSA;
                rxIf.rxWord_CML <= wordCML;
                rxIf.rxValid    <= 1'b1;
                frameCount      <= frameCount + 1'b1;
            end else if (overrunCount != '1) begin
                overrunCount <= overrunCount + 1'b1;
            end
        end else if (rxIf.rxValid && rxIf.rxReady) begin
            rxIf.rxValid <= 1'b0;
        end
    end

    // Saturating count of aborted frames.
    always_ff @(posedge serialClk or posedge serialReset) begin
        if (serialReset) begin
            framingErrCount <= '0;
        end else if (frameErr && framingErrCount != '1) begin
            framingErrCount <= framingErrCount + 1'b1;
        end
    end

    assign busy = (state == RX_SHIFT);

endmodule

// File: tb/tb_accumulator_serial_rx.sv
// Self-checking bench for accumulator_serial_rx (ACC_WIDTH=16).
// Frame-level reference model, directed scenarios plus random frames.
module tb_accumulator_serial_rx;

    localparam int W = 16;

    logic        serialClk = 1'b0;
    logic        serialReset = 1'b1;
    logic        rxEnable = 1'b0;
    logic        serialStart = 1'b0;
    logic        laneSA = 1'b0;
    logic        laneCML = 1'b0;
    logic [15:0] frameCount;
    logic [7:0]  framingErrCount;
    logic [7:0]  overrunCount;
    logic        busy;

    accumulator_serial_rx_if #(.ACC_WIDTH(W)) rxIf ();

    accumulator_serial_rx #(
        .ACC_WIDTH       (W),
        .CNT_WIDTH       (8),
        .FRAME_CNT_WIDTH (16)
    ) dut (
        .serialClk       (serialClk),
        .serialReset     (serialReset),
        .rxEnable        (rxEnable),
        .serialStart     (serialStart),
        .serialOut_SA    (laneSA),
        .serialOut_CML   (laneCML),
        .rxIf            (rxIf),
        .frameCount      (frameCount),
        .framingErrCount (framingErrCount),
        .overrunCount    (overrunCount),
        .busy            (busy)
    );

    always #5 serialClk = ~serialClk;

    // Reference model state (frame-level view of the link).
    bit        expValid;
    bit        expBusy;
    bit [15:0] expSA;
    bit [15:0] expCML;
    int        expFrames;
    int        expFerr;
    int        expOver;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag);
        chk({tag, ".valid"}, 32'(rxIf.rxValid), 32'(expValid));
        chk({tag, ".sa"}, 32'(rxIf.rxWord_SA), 32'(expSA));
        chk({tag, ".cml"}, 32'(rxIf.rxWord_CML), 32'(expCML));
        chk({tag, ".frames"}, 32'(frameCount), 32'(expFrames));
        chk({tag, ".ferr"}, 32'(framingErrCount), 32'(expFerr));
        chk({tag, ".over"}, 32'(overrunCount), 32'(expOver));
        chk({tag, ".busy"}, 32'(busy), 32'(expBusy));
    endtask

    task automatic modelReset();
        expValid  = 0;
        expBusy   = 0;
        expSA     = '0;
        expCML    = '0;
        expFrames = 0;
        expFerr   = 0;
        expOver   = 0;
    endtask

    function automatic int sat8(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Idle cycles: lane data is noise, consumer may drain.
    task automatic idle(input int n, input bit rdy);
        repeat (n) begin
            @(negedge serialClk);
            serialStart  = 1'b0;
            laneSA       = 1'($urandom);
            laneCML      = 1'($urandom);
            rxIf.rxReady = rdy;
            @(posedge serialClk);
            #1;
            if (rdy && expValid) expValid = 0;
            chkAll("idle");
        end
    endtask

    // Send the first n bits of a frame, MSB first. r0 is the ready
    // level on bits before the last, r1 on the completion bit.
    task automatic sendBits(input bit [15:0] wSA,
                            input bit [15:0] wCML,
                            input int n,
                            input bit r0,
                            input bit r1,
                            input bit enRand);
        for (int i = 0; i < n; i++) begin
            @(negedge serialClk);
            serialStart  = (i == 0);
            laneSA       = wSA[W-1-i];
            laneCML      = wCML[W-1-i];
            rxIf.rxReady = (i == W - 1) ? r1 : r0;
            if (i == 0) rxEnable = 1'b1;
            else if (enRand) rxEnable = 1'($urandom);
            @(posedge serialClk);
            #1;
            if (i == 0) begin
                if (expBusy) expFerr = sat8(expFerr);
                expBusy = 1;
            end
            if (i == W - 1) begin
                expBusy = 0;
                if (!expValid || r1) begin
                    expValid  = 1;
                    expSA     = wSA;
                    expCML    = wCML;
                    expFrames = (expFrames + 1) % 65536;
                end else begin
                    expOver = sat8(expOver);
                end
            end else if (r0 && expValid) begin
                expValid = 0;
            end
            chkAll((i == W - 1) ? "done" : "bit");
        end
        rxEnable = 1'b1;
    endtask

    initial begin
        int f0;
        int gap;
        int nb;
        bit [15:0] rs;
        bit [15:0] rc;

        modelReset();
        rxIf.rxReady = 1'b0;
        repeat (2) @(negedge serialClk);
        #1;
        chkAll("reset");
        serialReset = 1'b0;
        rxEnable    = 1'b1;

        // Single frame, consumer not ready.
        idle(8, 0);
        sendBits(16'hA5C3, 16'h0F0F, W, 0, 0, 0);
        chk("t1.sa", 32'(rxIf.rxWord_SA), 32'hA5C3);
        chk("t1.frames", 32'(frameCount), 32'd1);

        // Back-to-back frames with ready held high.
        idle(2, 1);
        f0 = expFrames;
        sendBits(16'h0001, 16'hFFFF, W, 1, 1, 0);
        sendBits(16'h8000, 16'h1234, W, 1, 1, 0);
        sendBits(16'hFFFF, 16'h0000, W, 1, 1, 0);
        chk("t2.frames", 32'(frameCount - 16'(f0)), 32'd3);
        chk("t2.cml", 32'(rxIf.rxWord_CML), 32'h0000);
        idle(2, 1);

        // Framing error: restart at bit 7.
        f0 = expFrames;
        sendBits(16'hFFFF, 16'hAAAA, 7, 1, 1, 0);
        sendBits(16'h1357, 16'h2468, W, 0, 0, 0);
        chk("t3.ferr", 32'(framingErrCount), 32'd1);
        chk("t3.word", 32'(rxIf.rxWord_SA), 32'h1357);
        chk("t3.one", 32'(frameCount - 16'(f0)), 32'd1);
        idle(2, 1);

        // Overrun, then consume coincident with completion.
        sendBits(16'h1111, 16'h0101, W, 0, 0, 0);
        idle(1, 0);
        sendBits(16'h2222, 16'h0202, W, 0, 0, 0);
        chk("t4.hold", 32'(rxIf.rxWord_SA), 32'h1111);
        chk("t4.over", 32'(overrunCount), 32'd1);
        sendBits(16'h3333, 16'h0303, W, 0, 1, 0);
        chk("t4.swap", 32'(rxIf.rxWord_SA), 32'h3333);
        chk("t4.valid", 32'(rxIf.rxValid), 32'd1);
        chk("t4.over2", 32'(overrunCount), 32'd1);
        idle(2, 1);

        // Reset at bit 9 clears everything immediately.
        sendBits(16'hDEAD, 16'hC0DE, 9, 0, 0, 0);
        @(negedge serialClk);
        serialReset = 1'b1;
        #1;
        modelReset();
        chkAll("rst");
        @(negedge serialClk);
        serialReset = 1'b0;
        sendBits(16'hBEEF, 16'h5A5A, W, 0, 0, 0);
        chk("t5.word", 32'(rxIf.rxWord_SA), 32'hBEEF);
        idle(2, 1);

        // Start ignored while disabled.
        @(negedge serialClk);
        rxEnable    = 1'b0;
        serialStart = 1'b1;
        laneSA      = 1'b1;
        @(posedge serialClk);
        #1;
        chk("t6.nobusy", 32'(busy), 32'd0);
        idle(W, 0);
        rxEnable = 1'b1;

        // Randomized frames: gaps, ready patterns, aborts.
        for (int k = 0; k < 30; k++) begin
            rs  = 16'($urandom);
            rc  = 16'($urandom);
            nb  = ($urandom_range(0, 4) == 0)
                  ? int'($urandom_range(1, W - 1)) : W;
            sendBits(rs, rc, nb, 1'($urandom), 1'($urandom), 1);
            if (nb == W) begin
                gap = $urandom_range(0, 3);
                if (gap > 0) idle(gap, 1'($urandom));
            end
        end
        sendBits(16'h0F0F, 16'hF0F0, W, 0, 0, 0);
        idle(2, 1);

        // Framing counter saturation: 300 aborted frames.
        serialReset = 1'b1;
        #1;
        modelReset();
        @(negedge serialClk);
        serialReset = 1'b0;
        for (int k = 0; k < 301; k++) begin
            sendBits(16'($urandom), 16'($urandom), 1, 0, 0, 0);
        end
        chk("t6.sat", 32'(framingErrCount), 32'd255);
        sendBits(16'h4242, 16'h2424, W, 0, 0, 0);
        chk("t6.sat2", 32'(framingErrCount), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
